// File: rtl/nonce_search_ctrl.sv
// Nonce search controller: issues nonces into the fixed-latency hash pipeline and captures the first hit.
// Optional abort input enabled by defining NONCE_ABORT_EN.
module nonce_search_ctrl #(
  parameter int unsigned NONCE_W  = 32,
  parameter int unsigned PIPE_LAT = 4,
  parameter int unsigned BOUNTY_W = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [NONCE_W-1:0]  start_nonce,
  input  logic [NONCE_W-1:0]  max_count,
`ifdef NONCE_ABORT_EN
  input  logic                abort,
`endif
  output logic [NONCE_W-1:0]  nonce_out,
  output logic                nonce_valid,
  input  logic                valid,
  input  logic [BOUNTY_W-1:0] bounty,
  output logic                busy,
  output logic                done,
  output logic                found,
  output logic [NONCE_W-1:0]  found_nonce,
  output logic [BOUNTY_W-1:0] found_bounty
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [NONCE_W-1:0]  issue_q, issue_d;
  logic [NONCE_W-1:0]  remaining_q, remaining_d;
  logic [NONCE_W-1:0]  result_q, result_d;
  logic [PIPE_LAT-1:0] tag_q, tag_d;
  logic                nonce_valid_q, nonce_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                found_q, found_d;
  logic [NONCE_W-1:0]  found_nonce_q, found_nonce_d;
  logic [BOUNTY_W-1:0] found_bounty_q, found_bounty_d;

  logic abort_c;
  logic in_search_c;
  logic nonce_valid_c;
  logic qual_c;
  logic hit_c;

`ifdef NONCE_ABORT_EN
  assign abort_c = abort;
`else
  assign abort_c = 1'b0;
`endif

  // Abort gates the issue strobe in the same cycle it is raised.
  assign in_search_c   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign nonce_valid_c = nonce_valid_q & ~(abort_c & in_search_c);
  assign qual_c        = tag_q[PIPE_LAT-1];
  assign hit_c         = in_search_c & ~abort_c & qual_c & valid & ~found_q;

  always_comb begin
    state_d        = state_q;
    issue_d        = issue_q;
    remaining_d    = remaining_q;
    result_d       = result_q;
    tag_d          = (tag_q << 1) | PIPE_LAT'(nonce_valid_c);
    found_d        = found_q;
    found_nonce_d  = found_nonce_q;
    found_bounty_d = found_bounty_q;

    if (qual_c) begin
      result_d = result_q + NONCE_W'(1);
    end

    // Only the first qualified hit of a search is kept.
    if (hit_c) begin
      found_d        = 1'b1;
      found_nonce_d  = result_q;
      found_bounty_d = bounty;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          found_d        = 1'b0;
          found_nonce_d  = '0;
          found_bounty_d = '0;
          issue_d        = start_nonce;
          remaining_d    = max_count;
          result_d       = start_nonce;
          state_d        = (max_count != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        issue_d     = issue_q + NONCE_W'(1);
        remaining_d = remaining_q - NONCE_W'(1);
        if (abort_c) begin
          tag_d   = '0;
          state_d = ST_DONE;
        end else if (hit_c || (remaining_q == NONCE_W'(1))) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (abort_c) begin
          tag_d   = '0;
          state_d = ST_DONE;
        end else if (tag_d == '0) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    nonce_valid_d = (state_d == ST_RUN);
    busy_d        = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d        = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      issue_q        <= '0;
      remaining_q    <= '0;
      result_q       <= '0;
      tag_q          <= '0;
      nonce_valid_q  <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      found_q        <= 1'b0;
      found_nonce_q  <= '0;
      found_bounty_q <= '0;
    end else begin
      state_q        <= state_d;
      issue_q        <= issue_d;
      remaining_q    <= remaining_d;
      result_q       <= result_d;
      tag_q          <= tag_d;
      nonce_valid_q  <= nonce_valid_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      found_q        <= found_d;
      found_nonce_q  <= found_nonce_d;
      found_bounty_q <= found_bounty_d;
    end
  end

  assign nonce_out    = issue_q;
  assign nonce_valid  = nonce_valid_c;
  assign busy         = busy_q;
  assign done         = done_q;
  assign found        = found_q;
  assign found_nonce  = found_nonce_q;
  assign found_bounty = found_bounty_q;

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Directed bench for nonce_search_ctrl: table of searches plus reset/abort sequences.
module tb_nonce_search_ctrl;

  localparam int unsigned LAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] start_nonce;
  logic [31:0] max_count;
  logic [31:0] nonce_out;
  logic        nonce_valid;
  logic        valid;
  logic [23:0] bounty;
  logic        busy;
  logic        done;
  logic        found;
  logic [31:0] found_nonce;
  logic [23:0] found_bounty;
`ifdef NONCE_ABORT_EN
  logic        abort;
`endif

  int n_checks = 0;
  int n_err    = 0;

  nonce_search_ctrl #(.NONCE_W(32), .PIPE_LAT(LAT), .BOUNTY_W(24)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .start_nonce  (start_nonce),
    .max_count    (max_count),
`ifdef NONCE_ABORT_EN
    .abort        (abort),
`endif
    .nonce_out    (nonce_out),
    .nonce_valid  (nonce_valid),
    .valid        (valid),
    .bounty       (bounty),
    .busy         (busy),
    .done         (done),
    .found        (found),
    .found_nonce  (found_nonce),
    .found_bounty (found_bounty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sn;
    logic [31:0] mc;
    int          hit_k;     // result index carrying the first valid, -1 none
    int          hit2_k;    // result index carrying a later valid, -1 none
    logic [23:0] bty;
    bit          pre_v;     // valid high before any result is in flight
    bit          restart;   // extra start pulse while busy
    int          exp_issued;
    int          exp_done;
    bit          exp_found;
    logic [31:0] exp_fn;
    logic [23:0] exp_fb;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          issued   = 0;
    int          done_cyc = -1;
    bit          seq_ok   = 1'b1;
    logic        f_at     = 1'b0;
    logic        b_at     = 1'b1;
    logic [31:0] fn_at    = '0;
    logic [23:0] fb_at    = '0;
    string       tag;
    tag = $sformatf("v%0d", idx);
    @(posedge clk); #1;
    start       = 1'b1;
    start_nonce = v.sn;
    max_count   = v.mc;
    valid       = 1'b0;
    for (int cyc = 1; cyc <= 60 && done_cyc < 0; cyc++) begin
      @(posedge clk); #1;
      start       = (v.restart && cyc == 3);
      start_nonce = (v.restart && cyc == 3) ? 32'h0000_0900 : 32'hDEAD_BEEF;
      max_count   = (v.restart && cyc == 3) ? 32'd2 : 32'd77;
      if (nonce_valid) begin
        if (nonce_out !== v.sn + 32'(issued)) seq_ok = 1'b0;
        issued++;
      end
      if (done) begin
        done_cyc = cyc;
        f_at  = found;
        fn_at = found_nonce;
        fb_at = found_bounty;
        b_at  = busy;
      end
      valid  = (v.hit_k >= 0 && cyc == 1 + v.hit_k + int'(LAT)) ||
               (v.hit2_k >= 0 && cyc == 1 + v.hit2_k + int'(LAT)) ||
               (v.pre_v && cyc <= int'(LAT));
      bounty = (v.hit2_k >= 0 && cyc == 1 + v.hit2_k + int'(LAT)) ? ~v.bty : v.bty;
    end
    valid = 1'b0;
    start = 1'b0;
    chk({tag, " nonce_seq"}, 32'(seq_ok), 32'd1);
    chk({tag, " issued"}, 32'(issued), 32'(v.exp_issued));
    chk({tag, " done_cycle"}, 32'(done_cyc), 32'(v.exp_done));
    chk({tag, " busy_at_done"}, 32'(b_at), 32'd0);
    chk({tag, " found"}, 32'(f_at), 32'(v.exp_found));
    chk({tag, " found_nonce"}, fn_at, v.exp_fn);
    chk({tag, " found_bounty"}, 32'(fb_at), 32'(v.exp_fb));
    @(posedge clk); #1;
    chk({tag, " done_pulse_end"}, 32'(done), 32'd0);
    chk({tag, " found_held"}, 32'(found), 32'(v.exp_found));
  endtask

  initial begin
    vecs[0] = '{32'h10, 32'd8, -1, -1, 24'h0, 1'b0, 1'b0, 8, 13, 1'b0, 32'h0, 24'h0};
    vecs[1] = '{32'h10, 32'd8, 3, 5, 24'h00ABCD, 1'b0, 1'b0, 8, 13, 1'b1, 32'h13, 24'h00ABCD};
    vecs[2] = '{32'hFFFF_FFFE, 32'd4, 2, -1, 24'h123456, 1'b0, 1'b0, 4, 9, 1'b1, 32'h0, 24'h123456};
    vecs[3] = '{32'h100, 32'd20, 0, 1, 24'h000001, 1'b0, 1'b0, 5, 10, 1'b1, 32'h100, 24'h000001};
    vecs[4] = '{32'hAAAA, 32'd0, -1, -1, 24'h0, 1'b0, 1'b0, 0, 1, 1'b0, 32'h0, 24'h0};
    vecs[5] = '{32'h20, 32'd3, -1, -1, 24'h777777, 1'b1, 1'b0, 3, 8, 1'b0, 32'h0, 24'h0};
    vecs[6] = '{32'h40, 32'd6, -1, -1, 24'h0, 1'b0, 1'b1, 6, 11, 1'b0, 32'h0, 24'h0};
    vecs[7] = '{32'h50, 32'd3, 2, -1, 24'h0F0F0F, 1'b0, 1'b0, 3, 8, 1'b1, 32'h52, 24'h0F0F0F};
    vecs[8] = '{32'h7FFF_FFFF, 32'd1, 0, -1, 24'hFFFFFF, 1'b0, 1'b0, 1, 6, 1'b1, 32'h7FFF_FFFF, 24'hFFFFFF};

    reset = 1'b1; start = 1'b1; start_nonce = 32'h5; max_count = 32'd5;
    valid = 1'b1; bounty = 24'h111111;
`ifdef NONCE_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst nonce_valid", 32'(nonce_valid), 32'd0);
    chk("rst nonce_out", nonce_out, 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst found", 32'(found), 32'd0);
    chk("rst found_nonce", found_nonce, 32'd0);
    chk("rst found_bounty", 32'(found_bounty), 32'd0);
    reset = 1'b0; start = 1'b0;
    // valid in IDLE is never qualified
    repeat (3) @(posedge clk);
    #1;
    chk("idle busy", 32'(busy), 32'd0);
    chk("idle found", 32'(found), 32'd0);
    valid = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Reset mid-RUN: no done pulse, search discarded.
    @(posedge clk); #1;
    start = 1'b1; start_nonce = 32'h10; max_count = 32'd8;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst nonce_valid", 32'(nonce_valid), 32'd0);
    chk("midrst found", 32'(found), 32'd0);
    begin
      int seen = 0;
      for (int c = 0; c < 20; c++) begin
        valid = c[0];
        @(posedge clk); #1;
        if (done || nonce_valid || busy) seen++;
      end
      valid = 1'b0;
      chk("midrst quiet", 32'(seen), 32'd0);
    end

`ifdef NONCE_ABORT_EN
    // Abort two cycles after start, nothing found.
    @(posedge clk); #1;
    start = 1'b1; start_nonce = 32'h10; max_count = 32'd8;
    @(posedge clk); #1;
    start = 1'b0;
    chk("abort1 nv_c1", 32'(nonce_valid), 32'd1);
    @(posedge clk); #1;
    abort = 1'b1;
    #1;
    chk("abort1 nv_gated", 32'(nonce_valid), 32'd0);
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort1 done", 32'(done), 32'd1);
    chk("abort1 busy", 32'(busy), 32'd0);
    chk("abort1 found", 32'(found), 32'd0);
    // Abort after a captured hit keeps it.
    @(posedge clk); #1;
    start = 1'b1; start_nonce = 32'h30; max_count = 32'd10;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      valid = (c == 5);
      bounty = 24'h00C0DE;
      abort = (c == 7);
    end
    @(posedge clk); #1;
    abort = 1'b0; valid = 1'b0;
    chk("abort2 done", 32'(done), 32'd1);
    chk("abort2 found", 32'(found), 32'd1);
    chk("abort2 found_nonce", found_nonce, 32'h30);
    chk("abort2 found_bounty", 32'(found_bounty), 32'h00C0DE);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
